// File: rtl/rom_arbiter_if.sv
// Bus bundle between the three memory requesters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the surrounding SoC / bench.
interface rom_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              lsu_req;
  logic              lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [3:0]        lsu_sel;
  logic              lsu_gnt;
  logic              lsu_rvalid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              ld_start;
  logic              ld_done;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_gnt;

  logic              cpu_hold;

  logic [ADDR_W-1:0] mem_r_addr;
  logic [DATA_W-1:0] mem_r_data;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [3:0]        mem_w_sel;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_sel,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    input  ld_start, ld_done, ld_req, ld_addr, ld_data,
    output ld_gnt,
    output cpu_hold,
    output mem_r_addr,
    input  mem_r_data,
    output mem_w_en, mem_w_addr, mem_w_data, mem_w_sel
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_sel,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    output ld_start, ld_done, ld_req, ld_addr, ld_data,
    input  ld_gnt,
    input  cpu_hold,
    input  mem_r_addr,
    output mem_r_data,
    input  mem_w_en, mem_w_addr, mem_w_data, mem_w_sel
  );
endinterface

// File: rtl/rom_arbiter.sv
// Single-port memory arbiter: fetch / LSU / program loader, fixed priority with fetch
// starvation guard, and a RUN -> DRAIN -> LOAD sequencer that holds the core during download.
module rom_arbiter #(
  parameter logic [2:0] STARVE_MAX = 3'd4,
  parameter int         ADDR_W     = 16,
  parameter int         DATA_W     = 32
) (
  input logic          clk,
  input logic          rst_n,
  rom_arbiter_if.slave bus
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic [2:0]        starve_r;
  logic [2:0]        starve_next_s;
  logic              run_s;
  logic              fetch_prio_s;
  logic              if_gnt_s;
  logic              lsu_gnt_s;
  logic              ld_gnt_s;
  logic              if_rvalid_r;
  logic              lsu_rvalid_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] lsu_rdata_r;
  logic              cpu_hold_r;
  logic [ADDR_W-1:0] mem_r_addr_s;
  logic              mem_w_en_s;
  logic [ADDR_W-1:0] mem_w_addr_s;
  logic [DATA_W-1:0] mem_w_data_s;
  logic [3:0]        mem_w_sel_s;

  function automatic logic [2:0] starve_inc(input logic [2:0] cnt);
    if (cnt >= STARVE_MAX) begin
      return STARVE_MAX;
    end else begin
      return cnt + 3'd1;
    end
  endfunction

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  assign run_s        = (state_r == RUN);
  assign fetch_prio_s = (starve_r == STARVE_MAX);
  assign if_gnt_s     = rst_n & run_s & bus.if_req & (~bus.lsu_req | fetch_prio_s);
  assign lsu_gnt_s    = rst_n & run_s & bus.lsu_req & ~(bus.if_req & fetch_prio_s);
  assign ld_gnt_s     = rst_n & (state_r == LOAD) & bus.ld_req;

  // Route the single granted requester onto the memory port; idle port is all zero.
  always_comb begin
    mem_r_addr_s = '0;
    mem_w_en_s   = 1'b0;
    mem_w_addr_s = '0;
    mem_w_data_s = '0;
    mem_w_sel_s  = 4'h0;
    if (if_gnt_s) begin
      mem_r_addr_s = bus.if_addr;
    end else if (lsu_gnt_s) begin
      if (bus.lsu_we) begin
        mem_w_en_s   = 1'b1;
        mem_w_addr_s = bus.lsu_addr;
        mem_w_data_s = bus.lsu_wdata;
        mem_w_sel_s  = bus.lsu_sel;
      end else begin
        mem_r_addr_s = bus.lsu_addr;
      end
    end else if (ld_gnt_s) begin
      mem_w_en_s   = 1'b1;
      mem_w_addr_s = bus.ld_addr;
      mem_w_data_s = bus.ld_data;
      mem_w_sel_s  = 4'hF;
    end else begin
      mem_w_en_s = 1'b0;
    end
  end

  // Mode sequencer next state; DRAIN lets the last CPU response retire before loading.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (bus.ld_start) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: state_next_s = LOAD;
      LOAD: begin
        if (bus.ld_done) begin
          state_next_s = RUN;
        end else begin
          state_next_s = LOAD;
        end
      end
      default: state_next_s = RUN;
    endcase
  end

  // Count consecutive denied fetch cycles in RUN; cleared when leaving RUN.
  always_comb begin
    starve_next_s = 3'd0;
    if (run_s && !bus.ld_start) begin
      if (bus.if_req && !if_gnt_s) begin
        starve_next_s = starve_inc(starve_r);
      end else begin
        starve_next_s = 3'd0;
      end
    end else begin
      starve_next_s = 3'd0;
    end
  end

  // State, starvation counter, hold and read responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RUN;
      starve_r     <= 3'd0;
      cpu_hold_r   <= 1'b0;
      if_rvalid_r  <= 1'b0;
      lsu_rvalid_r <= 1'b0;
      if_rdata_r   <= '0;
      lsu_rdata_r  <= '0;
    end else begin
      state_r      <= state_next_s;
      starve_r     <= starve_next_s;
      cpu_hold_r   <= (state_next_s != RUN);
      if_rvalid_r  <= if_gnt_s;
      lsu_rvalid_r <= lsu_gnt_s;
      if (if_gnt_s) begin
        if_rdata_r <= bus.mem_r_data;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      // A write ack leaves the previous read data in place.
      if (lsu_gnt_s && !bus.lsu_we) begin
        lsu_rdata_r <= bus.mem_r_data;
      end else begin
        lsu_rdata_r <= lsu_rdata_r;
      end
    end
  end

  assign bus.if_gnt     = if_gnt_s;
  assign bus.lsu_gnt    = lsu_gnt_s;
  assign bus.ld_gnt     = ld_gnt_s;
  assign bus.if_rvalid  = if_rvalid_r;
  assign bus.if_rdata   = if_rdata_r;
  assign bus.lsu_rvalid = lsu_rvalid_r;
  assign bus.lsu_rdata  = lsu_rdata_r;
  assign bus.cpu_hold   = cpu_hold_r;
  assign bus.mem_r_addr = mem_r_addr_s;
  assign bus.mem_w_en   = mem_w_en_s;
  assign bus.mem_w_addr = mem_w_addr_s;
  assign bus.mem_w_data = mem_w_data_s;
  assign bus.mem_w_sel  = mem_w_sel_s;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: cycle-by-cycle vector table against a small byte-write
// memory model, plus a hand-written asynchronous reset sequence.
module tb_rom_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  rom_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  rom_arbiter #(.STARVE_MAX(3'd4), .ADDR_W(16), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];

  assign bus.mem_r_data = mem[bus.mem_r_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_w_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_w_sel[b]) mem[bus.mem_w_addr[7:2]][8*b +: 8] <= bus.mem_w_data[8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic        if_req;
    logic [15:0] if_addr;
    logic        lsu_req;
    logic        lsu_we;
    logic [15:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_sel;
    logic        ld_start;
    logic        ld_done;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    logic        e_if_gnt;
    logic        e_lsu_gnt;
    logic        e_ld_gnt;
    logic        e_hold;
    logic        e_if_rv;
    logic [31:0] e_if_rd;
    logic        e_lsu_rv;
    logic [31:0] e_lsu_rd;
    logic        e_w_en;
    logic [3:0]  e_w_sel;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.if_req = 1'b0;    bus.if_addr = 16'h0;
    bus.lsu_req = 1'b0;   bus.lsu_we = 1'b0;   bus.lsu_addr = 16'h0;
    bus.lsu_wdata = 32'h0; bus.lsu_sel = 4'h0;
    bus.ld_start = 1'b0;  bus.ld_done = 1'b0;  bus.ld_req = 1'b0;
    bus.ld_addr = 16'h0;  bus.ld_data = 32'h0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[5] = 32'h55;

    // Columns: if_req,if_addr, lsu_req,we,addr,wdata,sel, ld_start,ld_done,ld_req,ld_addr,ld_data |
    //          if_gnt,lsu_gnt,ld_gnt,hold, if_rv,if_rd, lsu_rv,lsu_rd, w_en,w_sel
    vecs[0]  = '{1'b1,16'h0000, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 1'b0,32'h00000000, 1'b0,32'h00000000, 1'b0,4'h0};
    vecs[1]  = '{1'b1,16'h0004, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 1'b1,32'h00000011, 1'b0,32'h00000000, 1'b0,4'h0};
    vecs[2]  = '{1'b1,16'h0008, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 1'b1,32'h00000022, 1'b0,32'h00000000, 1'b0,4'h0};
    vecs[3]  = '{1'b0,16'h0000, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,1'b0,1'b0, 1'b1,32'h00000033, 1'b0,32'h00000000, 1'b0,4'h0};
    vecs[4]  = '{1'b0,16'h0000, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,1'b0,1'b0, 1'b0,32'h00000033, 1'b0,32'h00000000, 1'b0,4'h0};
    // Contention: LSU wins four cycles, then the starved fetch wins once.
    vecs[5]  = '{1'b1,16'h0000, 1'b1,1'b0,16'h0014,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,32'h00000033, 1'b0,32'h00000000, 1'b0,4'h0};
    vecs[6]  = '{1'b1,16'h0000, 1'b1,1'b0,16'h0014,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,32'h00000033, 1'b1,32'h00000055, 1'b0,4'h0};
    vecs[7]  = '{1'b1,16'h0000, 1'b1,1'b0,16'h0014,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,32'h00000033, 1'b1,32'h00000055, 1'b0,4'h0};
    vecs[8]  = '{1'b1,16'h0000, 1'b1,1'b0,16'h0014,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,32'h00000033, 1'b1,32'h00000055, 1'b0,4'h0};
    vecs[9]  = '{1'b1,16'h0000, 1'b1,1'b0,16'h0014,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 1'b0,32'h00000033, 1'b1,32'h00000055, 1'b0,4'h0};
    vecs[10] = '{1'b1,16'h0000, 1'b1,1'b0,16'h0014,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b1,32'h00000011, 1'b0,32'h00000055, 1'b0,4'h0};
    // Byte write then read-back of the same word.
    vecs[11] = '{1'b0,16'h0000, 1'b1,1'b1,16'h0010,32'hAABBCCDD,4'h5, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,32'h00000011, 1'b1,32'h00000055, 1'b1,4'h5};
    vecs[12] = '{1'b0,16'h0000, 1'b1,1'b0,16'h0010,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,32'h00000011, 1'b1,32'h00000055, 1'b0,4'h0};
    vecs[13] = '{1'b0,16'h0000, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,1'b0,1'b0, 1'b0,32'h00000011, 1'b1,32'h00BB00DD, 1'b0,4'h0};
    // Loader controls in RUN are ignored.
    vecs[14] = '{1'b0,16'h0000, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b1,1'b1,16'h0,32'h12345678, 1'b0,1'b0,1'b0,1'b0, 1'b0,32'h00000011, 1'b0,32'h00BB00DD, 1'b0,4'h0};
    // Start download while fetch streams: one last fetch, DRAIN, then LOAD.
    vecs[15] = '{1'b1,16'h0008, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b1,1'b0,1'b0,16'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 1'b0,32'h00000011, 1'b0,32'h00BB00DD, 1'b0,4'h0};
    vecs[16] = '{1'b1,16'h0008, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,1'b0,1'b1, 1'b1,32'h00000033, 1'b0,32'h00BB00DD, 1'b0,4'h0};
    vecs[17] = '{1'b1,16'h0008, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b1,1'b0,1'b1,16'h0000,32'hDEADBEEF, 1'b0,1'b0,1'b1,1'b1, 1'b0,32'h00000033, 1'b0,32'h00BB00DD, 1'b1,4'hF};
    vecs[18] = '{1'b1,16'h0008, 1'b1,1'b0,16'h0014,32'h0,4'h0, 1'b0,1'b0,1'b1,16'h0004,32'hCAFEF00D, 1'b0,1'b0,1'b1,1'b1, 1'b0,32'h00000033, 1'b0,32'h00BB00DD, 1'b1,4'hF};
    vecs[19] = '{1'b0,16'h0000, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b1,1'b1,16'h0008,32'h0BADF00D, 1'b0,1'b0,1'b1,1'b1, 1'b0,32'h00000033, 1'b0,32'h00BB00DD, 1'b1,4'hF};
    vecs[20] = '{1'b1,16'h0000, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 1'b0,32'h00000033, 1'b0,32'h00BB00DD, 1'b0,4'h0};
    vecs[21] = '{1'b1,16'h0004, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 1'b1,32'hDEADBEEF, 1'b0,32'h00BB00DD, 1'b0,4'h0};
    vecs[22] = '{1'b1,16'h0008, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 1'b1,32'hCAFEF00D, 1'b0,32'h00BB00DD, 1'b0,4'h0};
    vecs[23] = '{1'b0,16'h0000, 1'b0,1'b0,16'h0000,32'h0,4'h0, 1'b0,1'b0,1'b0,16'h0,32'h0, 1'b0,1'b0,1'b0,1'b0, 1'b1,32'h0BADF00D, 1'b0,32'h00BB00DD, 1'b0,4'h0};

    // Reset: a held request must not be granted while rst_n is low.
    drive_idle();
    rst_n = 1'b0;
    bus.if_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
    check("rst_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check("rst_if_rv", {31'd0, bus.if_rvalid}, 32'd0);
    check("rst_lsu_rd", bus.lsu_rdata, 32'd0);
    check("rst_w_en", {31'd0, bus.mem_w_en}, 32'd0);
    bus.if_req = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.if_req = vecs[i].if_req;       bus.if_addr = vecs[i].if_addr;
      bus.lsu_req = vecs[i].lsu_req;     bus.lsu_we = vecs[i].lsu_we;
      bus.lsu_addr = vecs[i].lsu_addr;   bus.lsu_wdata = vecs[i].lsu_wdata;
      bus.lsu_sel = vecs[i].lsu_sel;     bus.ld_start = vecs[i].ld_start;
      bus.ld_done = vecs[i].ld_done;     bus.ld_req = vecs[i].ld_req;
      bus.ld_addr = vecs[i].ld_addr;     bus.ld_data = vecs[i].ld_data;
      #1;
      check($sformatf("v%0d_if_gnt", i), {31'd0, bus.if_gnt}, {31'd0, vecs[i].e_if_gnt});
      check($sformatf("v%0d_lsu_gnt", i), {31'd0, bus.lsu_gnt}, {31'd0, vecs[i].e_lsu_gnt});
      check($sformatf("v%0d_ld_gnt", i), {31'd0, bus.ld_gnt}, {31'd0, vecs[i].e_ld_gnt});
      check($sformatf("v%0d_hold", i), {31'd0, bus.cpu_hold}, {31'd0, vecs[i].e_hold});
      check($sformatf("v%0d_if_rv", i), {31'd0, bus.if_rvalid}, {31'd0, vecs[i].e_if_rv});
      check($sformatf("v%0d_if_rd", i), bus.if_rdata, vecs[i].e_if_rd);
      check($sformatf("v%0d_lsu_rv", i), {31'd0, bus.lsu_rvalid}, {31'd0, vecs[i].e_lsu_rv});
      check($sformatf("v%0d_lsu_rd", i), bus.lsu_rdata, vecs[i].e_lsu_rd);
      check($sformatf("v%0d_w_en", i), {31'd0, bus.mem_w_en}, {31'd0, vecs[i].e_w_en});
      check($sformatf("v%0d_w_sel", i), {28'd0, bus.mem_w_sel}, {28'd0, vecs[i].e_w_sel});
    end

    // Reset right after an LSU read grant drops the pending response.
    @(negedge clk);
    drive_idle();
    bus.lsu_req = 1'b1;
    bus.lsu_addr = 16'h0014;
    #1;
    check("mr_lsu_gnt", {31'd0, bus.lsu_gnt}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_lsu_rv", {31'd0, bus.lsu_rvalid}, 32'd0);
    check("mr_lsu_rd", bus.lsu_rdata, 32'd0);
    check("mr_if_rd", bus.if_rdata, 32'd0);
    check("mr_lsu_gnt_low", {31'd0, bus.lsu_gnt}, 32'd0);
    check("mr_r_addr", {16'd0, bus.mem_r_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_regrant", {31'd0, bus.lsu_gnt}, 32'd1);
    check("mr_hold", {31'd0, bus.cpu_hold}, 32'd0);
    @(negedge clk);
    bus.lsu_req = 1'b0;
    #1;
    check("mr_post_rv", {31'd0, bus.lsu_rvalid}, 32'd1);
    check("mr_post_rd", bus.lsu_rdata, 32'h00000055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
